// File: rtl/lsu_ctrl.sv
// Load/store unit controller: single outstanding request against a combinational word memory,
// with sub-word loads, read-modify-write sub-word stores and error responses.
`timescale 1ns/1ps
module lsu_ctrl #(
  parameter int RAM_SIZE = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] ReadData
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [31:0] RAM_WORDS = 32'(RAM_SIZE);

  function automatic logic req_bad(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr[0];
      SZ_W:    bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad || ({2'b00, addr[31:2]} >= RAM_WORDS);
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = {{24{sgn & b[7]}}, b};
      SZ_H:    r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (size)
      SZ_B: begin
        case (lane)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  logic [1:0]  state_r, state_s;
  logic [31:0] idx_r;
  logic [1:0]  size_r, lane_r;
  logic        signed_r, write_r;
  logic [31:0] wdata_r;
  logic        latch_s;

  logic        ready_r;
  logic        resp_valid_r, resp_valid_s;
  logic        resp_err_r, resp_err_s;
  logic [31:0] resp_rdata_r, resp_rdata_s;
  logic [31:0] address_r, address_s;
  logic [31:0] write_data_r, write_data_s;
  logic        mem_write_r, mem_write_s;
  logic        mem_read_r, mem_read_s;

  // Next state plus next values of every registered output; strobes only leave IDLE/RESP at zero.
  always_comb begin
    state_s      = state_r;
    latch_s      = 1'b0;
    resp_valid_s = 1'b0;
    resp_err_s   = 1'b0;
    resp_rdata_s = 32'h0000_0000;
    address_s    = 32'h0000_0000;
    write_data_s = 32'h0000_0000;
    mem_write_s  = 1'b0;
    mem_read_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          latch_s = 1'b1;
          if (req_bad(req_size, req_addr)) begin
            state_s      = S_RESP;
            resp_valid_s = 1'b1;
            resp_err_s   = 1'b1;
          end else if (req_write && (req_size == SZ_W)) begin
            state_s      = S_WR;
            mem_write_s  = 1'b1;
            address_s    = {2'b00, req_addr[31:2]};
            write_data_s = req_wdata;
          end else begin
            // Loads and sub-word stores both start by reading the target word.
            state_s    = S_RD;
            mem_read_s = 1'b1;
            address_s  = {2'b00, req_addr[31:2]};
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD: begin
        if (write_r) begin
          state_s      = S_WR;
          mem_write_s  = 1'b1;
          address_s    = idx_r;
          write_data_s = merge_store(ReadData, wdata_r, size_r, lane_r);
        end else begin
          state_s      = S_RESP;
          resp_valid_s = 1'b1;
          resp_rdata_s = load_ext(ReadData, size_r, lane_r, signed_r);
        end
      end
      S_WR: begin
        state_s      = S_RESP;
        resp_valid_s = 1'b1;
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, latched request and registered outputs; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      idx_r        <= 32'h0000_0000;
      size_r       <= 2'b00;
      lane_r       <= 2'b00;
      signed_r     <= 1'b0;
      write_r      <= 1'b0;
      wdata_r      <= 32'h0000_0000;
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      address_r    <= 32'h0000_0000;
      write_data_r <= 32'h0000_0000;
      mem_write_r  <= 1'b0;
      mem_read_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      ready_r      <= (state_s == S_IDLE);
      resp_valid_r <= resp_valid_s;
      resp_err_r   <= resp_err_s;
      resp_rdata_r <= resp_rdata_s;
      address_r    <= address_s;
      write_data_r <= write_data_s;
      mem_write_r  <= mem_write_s;
      mem_read_r   <= mem_read_s;
      if (latch_s) begin
        idx_r    <= {2'b00, req_addr[31:2]};
        size_r   <= req_size;
        lane_r   <= req_addr[1:0];
        signed_r <= req_signed;
        write_r  <= req_write;
        wdata_r  <= req_wdata;
      end else begin
        idx_r    <= idx_r;
        size_r   <= size_r;
        lane_r   <= lane_r;
        signed_r <= signed_r;
        write_r  <= write_r;
        wdata_r  <= wdata_r;
      end
    end
  end

  assign req_ready  = ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign Address    = address_r;
  assign WriteData  = write_data_r;
  assign MemWrite   = mem_write_r;
  assign MemRead    = mem_read_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl against a byte-arithmetic reference memory model.
`timescale 1ns/1ps
module tb_lsu_ctrl;
  localparam int RAM = 256;
  localparam int AW  = 8;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, MemWrite, MemRead;
  logic [31:0] resp_rdata, Address, WriteData, ReadData;

  lsu_ctrl #(.RAM_SIZE(RAM)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .Address(Address),
    .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData)
  );

  always #5 clk = ~clk;

  // Attached data memory, preloadable from the stimulus process.
  logic [31:0] mem [RAM];
  logic        pl_en = 1'b0;
  logic [AW-1:0] pl_idx = '0;
  logic [31:0] pl_data = 32'h0;
  assign ReadData = (Address < 32'(RAM)) ? mem[Address[AW-1:0]] : 32'h0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (MemWrite && (Address < 32'(RAM))) mem[Address[AW-1:0]] <= WriteData;
  end

  // Bus monitor: strobe counts, overlap and the last addresses/data seen.
  int rd_total = 0, wr_total = 0, overlap_total = 0, resp_total = 0;
  logic [31:0] last_raddr = 32'h0, last_waddr = 32'h0, last_wdata = 32'h0;
  always @(negedge clk) begin
    if (MemRead) begin rd_total++; last_raddr = Address; end
    if (MemWrite) begin wr_total++; last_waddr = Address; last_wdata = WriteData; end
    if (MemRead && MemWrite) overlap_total++;
    if (resp_valid && !reset) resp_total++;
  end

  logic [31:0] ref_mem [RAM];
  int errors = 0, checks = 0, resp_exp = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour computed with shifts and masks on the reference memory.
  function automatic void model(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd, output logic [31:0] nw,
                                output int lat, output int nrd, output int nwr);
    logic [31:0] idx, old, mask, val;
    int sh;
    idx = a >> 2;
    sh  = 8 * int'(a % 4);
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (idx >= 32'(RAM));
    rd = 32'h0; nw = 32'h0; lat = 1; nrd = 0; nwr = 0;
    if (!err) begin
      old  = ref_mem[idx[AW-1:0]];
      mask = (sz == 2'd2) ? 32'hFFFF_FFFF : ((sz == 2'd1) ? 32'h0000_FFFF : 32'h0000_00FF);
      if (!w) begin
        val = (old >> sh) & mask;
        if (sg && sz != 2'd2 && val[(sz == 2'd1) ? 15 : 7]) val = val | ~mask;
        rd = val; lat = 2; nrd = 1;
      end else begin
        nw  = (old & ~(mask << sh)) | ((wd << sh) & (mask << sh));
        lat = (sz == 2'd2) ? 2 : 3;
        nrd = (sz == 2'd2) ? 0 : 1;
        nwr = 1;
      end
    end
  endfunction

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    logic err;
    logic [31:0] rd, nw;
    int lat, nrd, nwr, rd0, wr0, n;
    model(w, sz, sg, a, wd, err, rd, nw, lat, nrd, nwr);
    rd0 = rd_total; wr0 = wr_total;
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    resp_exp++;
    chk("latency", 32'(n), 32'(lat));
    chk("resp_err", 32'(resp_err), 32'(err));
    chk("resp_rdata", resp_rdata, rd);
    chk("memread_pulses", 32'(rd_total - rd0), 32'(nrd));
    chk("memwrite_pulses", 32'(wr_total - wr0), 32'(nwr));
    if (nrd != 0) chk("read_addr", last_raddr, a >> 2);
    if (nwr != 0) begin
      chk("write_addr", last_waddr, a >> 2);
      chk("write_data", last_wdata, nw);
      ref_mem[a[AW+1:2]] = nw;
    end
    got = resp_rdata;
    @(posedge clk); #1;
    chk("ready_after_resp", 32'(req_ready), 32'd1);
  endtask

  initial begin : stim
    logic [31:0] got, a;
    logic [1:0] sz;
    int wr0, rd0, rv, diffs, nresp, k, cyc;
    logic [31:0] b2b_addr [3];
    int acc_cyc [3];
    int rsp_cyc [3];
    logic [31:0] rsp_dat [3];
    logic acc_now;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    @(posedge clk); #1;
    for (int i = 0; i < RAM; i++) begin
      pl_en = 1'b1; pl_idx = AW'(i);
      pl_data = (i == 4) ? 32'h8899_AABB : $urandom;
      ref_mem[i] = pl_data;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    chk("rst_address", Address, 32'd0);
    chk("rst_writedata", WriteData, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
    chk("load_word", got, 32'h8899_AABB);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, got);
    chk("load_byte_signed", got, 32'hFFFF_FF88);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, got);
    chk("load_byte_unsigned", got, 32'h0000_0088);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h55, got);
    chk("rmw_writedata", last_wdata, 32'h8899_55BB);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);
    chk("load_after_rmw", got, 32'h8899_55BB);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, got);
    chk("load_half_signed", got, 32'hFFFF_8899);

    do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, got);
    do_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h1234_5678, got);
    do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, got);
    do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, got);

    // Reset while a halfword store sits in its read phase.
    rd0 = rd_total; wr0 = wr_total;
    req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0; req_addr = 32'h40;
    req_wdata = 32'hCAFE; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw_in_read", 32'(MemRead), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_no_write", 32'(MemWrite), 32'd0);
    chk("abort_no_resp", 32'(resp_valid), 32'd0);
    rv = 0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid || MemWrite || MemRead) rv++;
      @(posedge clk); #1;
    end
    chk("abort_quiet", 32'(rv), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_writes", 32'(wr_total - wr0), 32'd0);
    chk("abort_mem", mem[16], ref_mem[16]);

    // Reset wins over a simultaneous request.
    rd0 = rd_total;
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_priority_reads", 32'(rd_total - rd0), 32'd0);
    chk("reset_priority_ready", 32'(req_ready), 32'd1);

    // Three word loads with req_valid held high.
    for (int i = 0; i < 3; i++) b2b_addr[i] = 32'(4 * (30 + 7 * i));
    rd0 = rd_total;
    k = 0; nresp = 0; cyc = 0;
    for (int i = 0; i < 3; i++) begin acc_cyc[i] = -100; rsp_cyc[i] = 0; rsp_dat[i] = 32'h0; end
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = b2b_addr[0]; req_valid = 1'b1;
    while (nresp < 3 && cyc < 30) begin
      acc_now = req_ready && req_valid;
      @(posedge clk); #1;
      cyc++;
      if (acc_now) begin
        acc_cyc[k] = cyc;
        k++;
        if (k < 3) req_addr = b2b_addr[k];
        else req_valid = 1'b0;
      end
      if (resp_valid) begin
        rsp_cyc[nresp] = cyc; rsp_dat[nresp] = resp_rdata; nresp++;
      end
    end
    req_valid = 1'b0;
    resp_exp += 3;
    chk("b2b_responses", 32'(nresp), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_data", rsp_dat[i], ref_mem[b2b_addr[i][AW+1:2]]);
      chk("b2b_latency", 32'(rsp_cyc[i] - acc_cyc[i]), 32'd1);
      if (i > 0) chk("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    end
    chk("b2b_reads", 32'(rd_total - rd0), 32'd3);
    @(posedge clk); #1;

    for (int t = 0; t < 200; t++) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, RAM + 1)) * 32'd4 + 32'($urandom_range(0, 3));
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if (sz == 2'd1 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 31) == 0) a[31] = 1'b1;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, got);
    end

    diffs = 0;
    for (int i = 0; i < RAM; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_diffs", 32'(diffs), 32'd0);
    chk("strobe_overlap", 32'(overlap_total), 32'd0);
    chk("resp_count", 32'(resp_total), 32'(resp_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter RAM_SIZE, default 256, SHALL define the depth of the attached data memory in 32-bit words.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified for byte and halfword stores.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  valid with resp_valid: misaligned, illegal size, or out-of-range access.
REQ-014 Address  output  32  word index to data memory.
REQ-015 WriteData  output  32  word written to data memory.
REQ-016 MemWrite, MemRead  output  1 each  memory write and read strobes.
REQ-017 ReadData  input  32  combinational read data from memory at Address.

Function
REQ-018 Byte lanes SHALL be little-endian: byte n = bits 8n+7:8n of the word, selected by req_addr[1:0]; halfword 0 = bits 15:0, halfword 1 = bits 31:16.
REQ-019 Address SHALL equal {2'b00, addr[31:2]} of the latched request; Address, WriteData and both strobes SHALL be 0 in IDLE and RESP.
REQ-020 FSM states SHALL be IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-021 Handshake: a request is accepted on an edge where req_valid && req_ready; all request fields are latched then; req_* are ignored in all other states.
REQ-022 Error: size 11, halfword with addr[0] = 1, word with addr[1:0] != 0, or word index >= RAM_SIZE SHALL go IDLE -> RESP with resp_err = 1 and no strobe asserted.
REQ-023 Load: IDLE -> RD (MemRead = 1 for one cycle; ReadData captured at the end of that cycle) -> RESP; resp_valid occurs 2 cycles after acceptance.
REQ-024 Word store: IDLE -> WR (MemWrite = 1 for one cycle, WriteData = req_wdata) -> RESP; 2-cycle latency.
REQ-025 Byte or halfword store: IDLE -> RD (captures old word) -> WR (WriteData = old word with only the addressed lane replaced by low bits of req_wdata) -> RESP; 3-cycle latency.
REQ-026 Load extension: the selected byte or halfword SHALL be sign- or zero-extended per req_signed; word loads SHALL ignore req_signed.
REQ-027 RESP SHALL last exactly one cycle with resp_valid = 1, then return to IDLE; no response backpressure exists.
REQ-028 MemRead and MemWrite SHALL never be 1 in the same cycle, and each SHALL be asserted for at most one cycle per request.
REQ-029 Back-to-back: a new request SHALL be accepted no earlier than the cycle after RESP; minimum issue interval is 3 cycles.

Reset
REQ-030 While reset is sampled high: state = IDLE; req_ready = 1 in the following cycle; resp_valid, resp_err, resp_rdata, Address, WriteData, MemWrite and MemRead = 0.
REQ-031 Reset during RD or WR SHALL abort the request: no strobe in the cycle after the reset edge, no response, and memory contents untouched except for a write already strobed before the reset edge.
REQ-032 Reset SHALL take priority over a simultaneous request; a request presented with reset high SHALL NOT be accepted.

Verification
REQ-033 Load word: memory word 4 = 0x8899AABB; load size 10 at addr 0x10 -> MemRead pulses with Address = 4; 2 cycles after acceptance resp_valid = 1, resp_rdata = 0x8899AABB, resp_err = 0.
REQ-034 Signed/unsigned byte: same word; byte loads at 0x13 with req_signed = 1 then 0 -> resp_rdata 0xFFFFFF88, then 0x00000088.
REQ-035 Byte store RMW: word 4 = 0x8899AABB; store byte 0x55 at 0x11 -> RD then WR with WriteData = 0x889955BB; resp at +3 cycles; a subsequent load word returns 0x889955BB.
REQ-036 Errors: halfword load at 0x21, word store at 0x22, size 11, and word index 256 with RAM_SIZE = 256 -> each gives resp_err = 1 at +1 cycle with no MemRead or MemWrite pulse.
REQ-037 Reset mid-RMW: assert reset during RD of a halfword store -> no MemWrite pulse, no resp_valid, req_ready = 1 after reset deasserts, memory word unchanged.
REQ-038 Back-to-back: req_valid held high with 3 queued loads -> acceptances exactly 3 cycles apart, responses in order, and strobes never overlap.
